// File: rtl/maxpool_writer.sv
// maxpool_writer: streams window-ordered samples to an image buffer and writes per-channel pooled and flattened results.
module maxpool_writer #(
    parameter int DW      = 19,
    parameter int OW      = 20,
    parameter int IMG_W   = 64,
    parameter int CH      = 2,
    parameter int POOL    = 2,
    parameter int FLAT_EN = 1,
    parameter int AW      = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_avg,
    output logic          o_busy,
    output logic          o_wr,
    output logic [AW-1:0] o_addr,
    output logic [OW-1:0] o_data,
    output logic [2:0]    o_sel,
    output logic          o_done
);
    localparam int LP = $clog2(POOL);
    localparam int SW = DW + 2 * LP;
    localparam int NP = IMG_W / POOL;
    localparam int PW = $clog2(NP);
    localparam int KW = (CH > 1) ? $clog2(CH) : 1;
    localparam int NW = CH * (1 + FLAT_EN);
    localparam int JW = (NW > 1) ? $clog2(NW) : 1;

    logic [KW-1:0] k;
    logic [LP-1:0] dx, dy;
    logic [PW-1:0] pc, pr;
    logic [JW-1:0] j;
    logic          avg_mode;
    logic [DW-1:0] max_r [CH];
    logic [SW-1:0] sum_r [CH];

    logic          win_first, win_last, frame_first, flat;
    logic [KW-1:0] jk;
    logic [AW-1:0] p, samp_addr, pool_addr;
    logic [DW-1:0] pool_data;
    logic [2:0]    pool_sel;

    always_comb begin
        win_first   = dx == '0 && dy == '0;
        win_last    = k == KW'(CH - 1) && dx == LP'(POOL - 1) && dy == LP'(POOL - 1);
        frame_first = win_first && k == '0 && pc == '0 && pr == '0;
        flat        = j >= JW'(CH);
        jk          = flat ? KW'(j - JW'(CH)) : KW'(j);
        p           = AW'(pr) * AW'(NP) + AW'(pc);
        samp_addr   = (AW'(pr) * AW'(POOL) + AW'(dy)) * AW'(IMG_W) + AW'(pc) * AW'(POOL) + AW'(dx);
        pool_addr   = flat ? p * AW'(CH) + AW'(jk) : p;
        pool_sel    = flat ? 3'(1 + 2 * CH) : 3'(1 + CH) + 3'(jk);
        pool_data   = avg_mode ? DW'(sum_r[jk] >> (2 * LP)) : max_r[jk];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_busy   <= 1'b0;
            o_wr     <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
            o_sel    <= '0;
            o_done   <= 1'b0;
            k        <= '0;
            dx       <= '0;
            dy       <= '0;
            pc       <= '0;
            pr       <= '0;
            j        <= '0;
            avg_mode <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                max_r[i] <= '0;
                sum_r[i] <= '0;
            end
        end else begin
            o_wr   <= 1'b0;
            o_done <= 1'b0;
            if (o_busy) begin
                o_wr   <= 1'b1;
                o_addr <= pool_addr;
                o_data <= OW'(pool_data);
                o_sel  <= pool_sel;
                j      <= j + 1'b1;
                // window counters advance only once its pooled results are out
                if (j == JW'(NW - 1)) begin
                    o_busy <= 1'b0;
                    j      <= '0;
                    o_done <= pc == '1 && pr == '1;
                    pc     <= pc + 1'b1;
                    if (pc == '1)
                        pr <= pr + 1'b1;
                end
            end else if (i_valid) begin
                o_wr     <= 1'b1;
                o_addr   <= samp_addr;
                o_data   <= OW'(i_data);
                o_sel    <= 3'(k) + 3'd1;
                if (frame_first)
                    avg_mode <= i_avg;
                max_r[k] <= (win_first || i_data > max_r[k]) ? i_data : max_r[k];
                sum_r[k] <= (win_first ? '0 : sum_r[k]) + SW'(i_data);
                if (k == KW'(CH - 1)) begin
                    k  <= '0;
                    dx <= dx + 1'b1;
                    if (dx == LP'(POOL - 1))
                        dy <= dy + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
                if (win_last)
                    o_busy <= 1'b1;
            end
        end
    end
endmodule
